serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial multi-bit subtractor that computes diff = a - b - bin over WIDTH bits, processing one bit per clock, LSB first.
- Each bit slice is a full subtractor built from two half-subtractor stages plus a registered borrow. The block is the sequencing stage that feeds the half-subtractor logic and consumes its dif/bor outputs.
- Valid/ready handshake on the operand side and on the result side.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  difference a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
- busy  output  1  high in SHIFT and DONE states

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - diff = 0; bout = 0; internal shift registers, borrow flop and counter all cleared.
- States: IDLE, SHIFT, DONE. Encoding is an enum from the package.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid && in_ready: load a_sh <= a, b_sh <= b, brw <= bin, cnt <= 0, then go to SHIFT.
  - in_valid while not in IDLE is ignored; the operands are not captured.
- SHIFT:
  - in_ready = 0.
  - Each cycle, the bit slice takes x = a_sh[0], y = b_sh[0], c = brw:
    - d = x ^ y ^ c
    - new borrow = (~x & y) | (~(x ^ y) & c)
  - d shifts into the MSB of res_sh and res_sh shifts right. a_sh and b_sh shift right. brw <= new borrow. cnt <= cnt + 1.
  - When cnt == WIDTH-1 on an edge, the last bit is processed. On that same edge: go to DONE, diff <= final res_sh, bout <= final borrow, out_valid <= 1.
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge. WIDTH=1 gives DONE one edge after accept.
- DONE:
  - out_valid = 1. diff and bout are held stable while out_ready = 0.
  - On an edge with out_ready = 1: out_valid <= 0, go to IDLE.
  - in_ready stays 0 in this cycle; there is no same-cycle accept.
  - Minimum throughput is one result per WIDTH+2 cycles.
- diff/bout after hand-off: retain the last result until the next DONE. They are only meaningful while out_valid = 1.
- Counter width is $clog2(WIDTH+1); the counter never wraps during operation.
- Reset asserted mid-SHIFT or mid-DONE: the operation is aborted and all outputs take their reset values immediately. After rst_n deasserts, the next operation is unaffected by the aborted one.
- out_ready asserted outside DONE has no effect.
- Arithmetic is unsigned modulo 2^WIDTH. bout is the borrow out of the MSB.

Decomposition:
- Package serial_sub_pkg:
  - state enum sub_state_t {IDLE, SHIFT, DONE}
  - localparam function for the counter width
- Sub-module full_sub_bit (inputs x, y, c; outputs d, bo):
  - Two cascaded half-subtraction stages.
  - bo is the OR of the two stage borrows.
  - Purely combinational, instantiated once.
- Top level holds the FSM, shift registers, borrow flop and counter.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0 -> out_valid rises 8 edges after accept; diff=0x1E, bout=0.
- WIDTH=8, a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1. Also a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Backpressure: complete a=0x80, b=0x01, then hold out_ready=0 for 5 cycles:
  - diff=0x7F and bout=0 stay stable throughout.
  - in_ready stays 0; a new in_valid pulse is ignored.
  - Release out_ready -> IDLE next edge.
- Reset mid-operation: assert rst_n=0 on the 3rd SHIFT cycle -> outputs go to 0 and in_ready to 1 at once. Then a=0xFF, b=0x01 -> diff=0xFE, bout=0.
- WIDTH=1 and WIDTH=4: exhaustive sweep of all (a, b, bin) against a reference model -> every result matches and latency equals WIDTH.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Counter must hold 0..WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_sub_bit.sv
// One-bit full subtractor: two cascaded half subtractors, borrows ORed.
module full_sub_bit (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);
    logic d1, b1, b2;

    always_comb begin
        d1 = x ^ y;
        b1 = ~x & y;
        d  = d1 ^ c;
        b2 = ~d1 & c;
        bo = b1 | b2;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock LSB first, valid/ready on both sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);
    localparam int CW = cnt_width(WIDTH);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_d, bit_bo;

    full_sub_bit u_bit (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .c  (brw_q),
        .d  (bit_d),
        .bo (bit_bo)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    brw_d    = bin;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // New bit enters at the MSB so after WIDTH shifts bit 0 is the LSB result.
                res_sh_d = WIDTH'({bit_d, res_sh_q} >> 1);
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                brw_d    = bit_bo;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = res_sh_d;
                    bout_d  = bit_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule
